// File: rtl/mcalu_issue_arb.sv
// mcalu_issue_arb: oldest-first issue arbiter feeding a single mcalu issue register
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid/op/robid/rd/op1/op2  packed per-requester ready-to-issue ops (requester i in slice i)
//   req_ready                      one-hot combinational grant
//   rob_head, rob_flush            ROB head id for age ranking, pipeline flush
//   mcalu_stall                    mcalu cannot accept the held op this cycle
//   exers_*                        registered issue interface to mcalu
//   arb_busy_cycles                saturating count of cycles an issued op sat stalled
module mcalu_issue_arb #(
  parameter int NREQ = 2,
  parameter int ROBW = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*5-1:0]    req_op,
  input  logic [NREQ*ROBW-1:0] req_robid,
  input  logic [NREQ*6-1:0]    req_rd,
  input  logic [NREQ*32-1:0]   req_op1,
  input  logic [NREQ*32-1:0]   req_op2,
  output logic [NREQ-1:0]      req_ready,
  input  logic [ROBW-1:0]      rob_head,
  input  logic                 rob_flush,
  input  logic                 mcalu_stall,
  output logic                 exers_mcalu_issue,
  output logic [4:0]           exers_mcalu_op,
  output logic [ROBW-1:0]      exers_robid,
  output logic [5:0]           exers_rd,
  output logic [31:0]          exers_op1,
  output logic [31:0]          exers_op2,
  output logic [15:0]          arb_busy_cycles
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  logic            ld, found;
  logic [ROBW-1:0] age, best_age;
  logic [IW-1:0]   best_idx;
  logic [4:0]      w_op;
  logic [ROBW-1:0] w_robid;
  logic [5:0]      w_rd;
  logic [31:0]     w_op1, w_op2;
  assign ld = ~exers_mcalu_issue | ~mcalu_stall;
  // Age is distance from the ROB head modulo 2^ROBW, so wrap-around ranks correctly;
  // strict compare keeps the lowest index on duplicate ages.
  always_comb begin
    found    = 1'b0;
    age      = '0;
    best_age = '0;
    best_idx = '0;
    w_op     = '0;
    w_robid  = '0;
    w_rd     = '0;
    w_op1    = '0;
    w_op2    = '0;
    for (int i = 0; i < NREQ; i++) begin
      age = req_robid[i*ROBW +: ROBW] - rob_head;
      if (req_valid[i] && (!found || age < best_age)) begin
        found    = 1'b1;
        best_age = age;
        best_idx = IW'(i);
        w_op     = req_op[i*5 +: 5];
        w_robid  = req_robid[i*ROBW +: ROBW];
        w_rd     = req_rd[i*6 +: 6];
        w_op1    = req_op1[i*32 +: 32];
        w_op2    = req_op2[i*32 +: 32];
      end
    end
  end
  assign req_ready = (ld && !rob_flush && found) ? NREQ'(1) << best_idx : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exers_mcalu_issue <= 1'b0;
      exers_mcalu_op    <= '0;
      exers_robid       <= '0;
      exers_rd          <= '0;
      exers_op1         <= '0;
      exers_op2         <= '0;
      arb_busy_cycles   <= '0;
    end else begin
      if (rob_flush) exers_mcalu_issue <= 1'b0;
      else if (ld) begin
        exers_mcalu_issue <= found;
        if (found) begin
          exers_mcalu_op <= w_op;
          exers_robid    <= w_robid;
          exers_rd       <= w_rd;
          exers_op1      <= w_op1;
          exers_op2      <= w_op2;
        end
      end
      if (exers_mcalu_issue && mcalu_stall && arb_busy_cycles != 16'hFFFF)
        arb_busy_cycles <= arb_busy_cycles + 16'd1;
    end
  end
endmodule
